// File: rtl/accumulator_drain.sv
// Drains the accumulator back buffer through the bank read port, pairing 16-bit reads into 32-bit words.
// Optional per-element ReLU at the latched bitwidth when ACCUM_DRAIN_RELU_EN is defined.
module accumulator_drain #(
   parameter int BUFFER_WIDTH           = 8,
   parameter int TILE_SIZE              = 256,
   parameter int SMALLEST_ELEMENT_WIDTH = 4,
   parameter int BANK_COUNT             = 256
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [1:0]                      bitwidth,
   output logic [$clog2(BUFFER_WIDTH)-1:0] bank_entry,
   output logic [$clog2(TILE_SIZE)-1:0]    bank_read,
   input  logic [4*SMALLEST_ELEMENT_WIDTH-1:0] bank_data,
   output logic [8*SMALLEST_ELEMENT_WIDTH-1:0] out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            busy,
   output logic                            done
);

   localparam int SEW = SMALLEST_ELEMENT_WIDTH;
   localparam int RW  = 4 * SEW;
   localparam int OW  = 8 * SEW;
   localparam int EW  = $clog2(BUFFER_WIDTH);
   localparam int BW  = $clog2(TILE_SIZE);

   localparam logic [EW-1:0] LAST_E = EW'(BUFFER_WIDTH - 1);
   localparam logic [BW-1:0] LAST_B = BW'(BANK_COUNT - 1);

   localparam logic [OW-1:0] MSB_N = {8{1'b1, {(SEW-1){1'b0}}}};
   localparam logic [OW-1:0] MSB_B = {4{1'b1, {(2*SEW-1){1'b0}}}};
   localparam logic [OW-1:0] MSB_H = {2{1'b1, {(4*SEW-1){1'b0}}}};

`ifdef ACCUM_DRAIN_RELU_EN
   localparam bit RELU_EN = 1'b1;
`else
   localparam bit RELU_EN = 1'b0;
`endif

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]    state;
   logic [1:0]    bw_q;
   logic [EW-1:0] next_e;
   logic [BW-1:0] next_b;
   logic          inflight;
   logic [RW-1:0] mem [4];
   logic [1:0]    wr_ptr;
   logic [1:0]    rd_ptr;
   logic [2:0]    count;

   logic [3:0]    occ;
   logic          accept;
   logic          issue;
   logic [EW-1:0] issue_e;
   logic [BW-1:0] issue_b;
   logic          last_issue;
   logic          pop;
   logic          drained;
   logic [OW-1:0] pair;
   logic [OW-1:0] packed_word;

   // Spread each negative element's sign bit down across the element, then clear those bits.
   function automatic logic [OW-1:0] relu_word(input logic [OW-1:0] w, input logic [1:0] code);
      logic [OW-1:0] msb;
      logic [OW-1:0] kill;
      int unsigned   ew;
      case (code)
         2'd0:    begin msb = MSB_N; ew = SEW;     end
         2'd1:    begin msb = MSB_B; ew = 2 * SEW; end
         default: begin msb = MSB_H; ew = 4 * SEW; end
      endcase
      kill = msb & w;
      for (int unsigned s = 1; s < 4 * SEW; s++) begin
         if (s < ew) kill = kill | ((msb & w) >> s);
      end
      return w & ~kill;
   endfunction

   always_comb begin
      occ         = {1'b0, count} + {3'b000, inflight};
      accept      = (state == IDLE) && start;
      issue       = accept || ((state == READ) && (occ < 4'd4));
      issue_e     = accept ? '0 : next_e;
      issue_b     = accept ? '0 : next_b;
      last_issue  = (issue_e == LAST_E) && (issue_b == LAST_B);
      pop         = (!out_valid || out_ready) && (count >= 3'd2);
      drained     = (count == 3'd0) && !inflight && !out_valid;
      pair        = {mem[rd_ptr + 2'd1], mem[rd_ptr]};
      packed_word = RELU_EN ? relu_word(pair, bw_q) : pair;
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // First address goes out on the accepting edge so the first word pair lands two cycles later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bw_q       <= '0;
         next_e     <= '0;
         next_b     <= '0;
         bank_entry <= '0;
         bank_read  <= '0;
         inflight   <= 1'b0;
      end else begin
         case (state)
            IDLE:  if (start) begin
                      state <= READ;
                      bw_q  <= bitwidth;
                   end
            READ:  if (issue && last_issue) state <= FLUSH;
            FLUSH: if (drained) state <= DONE;
            default: state <= IDLE;
         endcase
         inflight <= issue;
         if (issue) begin
            bank_entry <= issue_e;
            bank_read  <= issue_b;
            if (issue_b == LAST_B) begin
               next_b <= '0;
               next_e <= issue_e + 1'b1;
            end else begin
               next_b <= issue_b + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (inflight) mem[wr_ptr] <= bank_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (inflight) wr_ptr <= wr_ptr + 2'd1;
         if (pop) rd_ptr <= rd_ptr + 2'd2;
         count <= count + {2'b00, inflight} - (pop ? 3'd2 : 3'd0);
         if (pop) begin
            out_data  <= packed_word;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_accumulator_drain.sv
// Randomized drain bench for accumulator_drain against a word-level model of the walk and packing rules.
module tb_accumulator_drain;

   localparam int BUFW  = 2;
   localparam int BANKS = 4;
   localparam int TOTAL = BANKS * BUFW / 2;

`ifdef ACCUM_DRAIN_RELU_EN
   localparam bit RELU_ON = 1'b1;
`else
   localparam bit RELU_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  bitwidth = 2'd2;
   logic [0:0]  bank_entry;
   logic [7:0]  bank_read;
   logic [15:0] bank_data;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        busy;
   logic        done;

   logic [15:0] mask = '0;
   logic        cmode = 1'b0;
   logic [15:0] cword = '0;

   int n_vec = 0;
   int n_err = 0;

   accumulator_drain #(
      .BUFFER_WIDTH(BUFW),
      .TILE_SIZE(256),
      .SMALLEST_ELEMENT_WIDTH(4),
      .BANK_COUNT(BANKS)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .bitwidth(bitwidth),
      .bank_entry(bank_entry), .bank_read(bank_read), .bank_data(bank_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Bank returns data for the address the DUT is currently presenting.
   assign bank_data = cmode ? cword : ({bank_read, 7'b0, bank_entry} ^ mask);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] relu16(input logic [15:0] h, input logic [1:0] bw);
      logic [15:0] r;
      int w;
      int lo;
      int elem;
      r = h;
      w = (bw == 2'd0) ? 4 : (bw == 2'd1) ? 8 : 16;
      for (int j = 0; j < 16 / w; j++) begin
         lo   = j * w;
         elem = (int'(h) >> lo) & ((1 << w) - 1);
         if (elem >= (1 << (w - 1))) r = r & ~16'(((1 << w) - 1) << lo);
      end
      return RELU_ON ? r : h;
   endfunction

   function automatic logic [15:0] loc_data(input int l, input logic [15:0] m, input logic cm,
                                            input logic [15:0] cw);
      logic [7:0] e;
      logic [7:0] b;
      e = 8'(l / BANKS);
      b = 8'(l % BANKS);
      return cm ? cw : ({b, e} ^ m);
   endfunction

   function automatic logic [31:0] model_word(input int k, input logic [15:0] m, input logic cm,
                                              input logic [15:0] cw, input logic [1:0] bw);
      return {relu16(loc_data(2 * k + 1, m, cm, cw), bw), relu16(loc_data(2 * k, m, cm, cw), bw)};
   endfunction

   function automatic logic [8:0] exp_addr(input int idx);
      return {8'(idx % BANKS), 1'(idx / BANKS)};
   endfunction

   // ---------------- model / compare process ----------------
   int          issue_cnt = 0;
   int          hs_cnt = 0;
   int          sa = 0;
   int          since_last = 0;
   int          outst;
   bit          model_busy = 0;
   bit          acc_pending = 0;
   bit          fin_pending = 0;
   bit          prev_stall = 0;
   bit          done_seen = 0;
   logic [31:0] prev_data = '0;
   logic [8:0]  prev_addr = '0;
   logic [8:0]  cur_addr;
   logic [1:0]  lat_bw = '0;
   logic [15:0] lat_mask = '0;
   logic        lat_cmode = 1'b0;
   logic [15:0] lat_cword = '0;

   always @(negedge clk) begin
      if (reset) begin
         issue_cnt = 0; hs_cnt = 0; sa = 0; since_last = 0;
         model_busy = 0; acc_pending = 0; fin_pending = 0; prev_stall = 0;
         prev_addr = '0;
      end else begin
         if (fin_pending) since_last++;
         if (model_busy) sa++;
         cur_addr = {bank_read, bank_entry};
         if (acc_pending) begin
            acc_pending = 0; model_busy = 1; sa = 1; issue_cnt = 1; hs_cnt = 0;
            chk("first_addr", cur_addr, 0);
         end else if (cur_addr != prev_addr) begin
            chk("addr_order", cur_addr, exp_addr(issue_cnt));
            issue_cnt++;
            chk("issue_in_drain", model_busy && issue_cnt <= TOTAL * 2, 1);
         end
         prev_addr = cur_addr;

         chk("done", done, fin_pending && since_last == 2);
         chk("busy", busy, model_busy && !(fin_pending && since_last >= 3));
         if (done) done_seen = 1;
         if (fin_pending && since_last >= 3) begin
            model_busy = 0; fin_pending = 0;
         end
         if (!model_busy || fin_pending) chk("valid_when_empty", out_valid, 0);
         if (model_busy && sa <= 4) chk("first_valid_latency", out_valid, sa == 4);
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
         end
         if (model_busy) begin
            outst = issue_cnt - 2 * (hs_cnt + int'(out_valid));
            chk("outstanding_le4", outst >= 0 && outst <= 4, 1);
         end

         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (out_valid && out_ready) begin
            chk("hs_in_range", hs_cnt < TOTAL, 1);
            chk("word", out_data, model_word(hs_cnt, lat_mask, lat_cmode, lat_cword, lat_bw));
            hs_cnt++;
            if (hs_cnt == TOTAL) begin
               fin_pending = 1; since_last = 0;
            end
         end
         if (start && !model_busy) begin
            acc_pending = 1;
            lat_bw = bitwidth; lat_mask = mask; lat_cmode = cmode; lat_cword = cword;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input logic [15:0] m, input logic cm, input logic [15:0] cw,
                        input logic [1:0] bw, input int mode, input bit poke, input int abort_hs);
      bit aborted;
      aborted = 0;
      done_seen = 0;
      mask = m; cmode = cm; cword = cw; bitwidth = bw; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 400; c++) begin
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = !(c >= 3 && c <= 12);
            default: out_ready = ($urandom_range(0, 9) < 6);
         endcase
         if (mode == 2) bitwidth = 2'($urandom);
         start = poke && (c == 4);
         if (abort_hs > 0 && hs_cnt >= abort_hs) begin
            #2 reset = 1'b1;
            #1;
            chk("abort_out_valid", out_valid, 0);
            chk("abort_out_data", out_data, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_addr", {bank_read, bank_entry}, 0);
            start = 1'b0;
            tick(); tick();
            reset = 1'b0;
            aborted = 1;
            break;
         end
         tick();
         if (done_seen) break;
      end
      start = 1'b0;
      out_ready = 1'b1;
      if (!aborted) chk("drain_completed", done_seen, 1);
      tick(); tick(); tick();
   endtask

   initial begin
      #2;
      chk("rst_out_data", out_data, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", {bank_read, bank_entry}, 0);
      tick(); tick();
      reset = 1'b0;
      repeat (20) tick();

      chk("model_w0", model_word(0, 16'h0, 1'b0, 16'h0, 2'd2), 32'h01000000);
      chk("model_w1", model_word(1, 16'h0, 1'b0, 16'h0, 2'd2), 32'h03000200);
      chk("model_w2", model_word(2, 16'h0, 1'b0, 16'h0, 2'd2), 32'h01010001);
      chk("model_w3", model_word(3, 16'h0, 1'b0, 16'h0, 2'd2), 32'h03010201);
      chk("model_relu_b8", relu16(16'h80FF, 2'd1), RELU_ON ? 32'h0000 : 32'h80FF);
      chk("model_relu_b4", relu16(16'h7F8A, 2'd0), RELU_ON ? 32'h7000 : 32'h7F8A);
      chk("model_relu_b16", relu16(16'h7F8A, 2'd2), 32'h7F8A);

      drain(16'h0, 1'b0, 16'h0, 2'd2, 0, 0, 0);
      drain(16'h0, 1'b0, 16'h0, 2'd2, 1, 0, 0);
      drain(16'h0, 1'b1, 16'h80FF, 2'd1, 0, 0, 0);
      drain(16'h0, 1'b1, 16'h7F8A, 2'd0, 0, 0, 0);
      drain(16'h0, 1'b1, 16'h7F8A, 2'd2, 0, 0, 0);
      drain(16'h0, 1'b0, 16'h0, 2'd2, 0, 1, 0);
      drain(16'h0, 1'b0, 16'h0, 2'd2, 0, 0, 2);
      drain(16'h0, 1'b0, 16'h0, 2'd2, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         drain(16'($urandom), 1'b0, 16'h0, 2'($urandom), 2, ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
